dmem_responder: RTL and testbench

//  Data-memory responder: the far end of the dmem request interface that the MEM stage drives.

---
 rtl/dmem_responder.sv | 184 ++++++++++++++++++
 tb/tb_dmem_responder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//
// The data-memory end of the MEM stage's dmem request interface. It takes
// one load or store at a time, holds a private copy of it, and services it
// against an internal word-addressed array after LATENCY cycles. Completion
// is a single-cycle dmem_resp pulse.
//
// Handshake: there is no valid bit. A request is any cycle in IDLE with a
// nonzero rmask or wmask, and it is accepted on that rising edge. The
// initiator keeps MEM stalled until dmem_resp; while the responder is busy
// (WAIT, RESP) its inputs are ignored, so the earliest next acceptance is
// the IDLE cycle that follows the response.
//
// Parameters
//   DEPTH_LOG2  log2 of array depth in 32-bit words
//   LATENCY     cycles from acceptance to dmem_resp, 1..15
//
// Ports
//   clk          clock, rising edge
//   rst_n        synchronous active-low reset
//   dmem_addr    byte address; [DEPTH_LOG2+1:2] selects the word
//   dmem_rmask   byte read mask, nonzero = load
//   dmem_wmask   byte write mask, nonzero = store
//   dmem_wdata   lane-shifted store data
//   dmem_rdata   full word read, nonzero only while dmem_resp=1
//   dmem_resp    one-cycle completion pulse
//   dbg_state_o  current FSM state (0=IDLE, 1=WAIT, 2=RESP)
// ---------------------------------------------------------------------------
module dmem_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_rmask,
    input  logic [3:0]  dmem_wmask,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        dmem_resp,
    output logic [1:0]  dbg_state_o
);

    localparam int          DEPTH  = 1 << DEPTH_LOG2;
    localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0]  idx_q;
    logic [3:0]             rmask_q, wmask_q;
    logic [31:0]            wdata_q;
    logic [31:0]            rdata_q, rdata_d;

    logic                   req;
    logic                   capture;
    logic                   enter_resp;

    logic [DEPTH_LOG2-1:0]  acc_idx;
    logic [3:0]             acc_rmask;
    logic [3:0]             acc_wmask;
    logic [31:0]            acc_wdata;

    logic [31:0]            mem_q [DEPTH];

    // Address bits outside the word index are deliberately ignored.
    logic                   unused_addr_bits;
    assign unused_addr_bits = ^{dmem_addr[31:DEPTH_LOG2+2], dmem_addr[1:0]};

    assign req = (|dmem_rmask) | (|dmem_wmask);

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        capture    = 1'b0;
        enter_resp = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    capture = 1'b1;
                    cnt_d   = LAT_M1;
                    if (LATENCY == 1) begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d    = S_RESP;
                    enter_resp = 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // With LATENCY==1 the array is accessed on the acceptance edge itself,
    // before the captured copy exists, so the live inputs are used there.
    // From WAIT only the captured copy is ever used.
    always_comb begin
        if (state_q == S_IDLE) begin
            acc_idx   = dmem_addr[DEPTH_LOG2+1:2];
            acc_rmask = dmem_rmask;
            acc_wmask = dmem_wmask;
            acc_wdata = dmem_wdata;
        end else begin
            acc_idx   = idx_q;
            acc_rmask = rmask_q;
            acc_wmask = wmask_q;
            acc_wdata = wdata_q;
        end
    end

    // Read data is registered on RESP entry and cleared otherwise, so it
    // is zero in every cycle except the response cycle of a load.
    always_comb begin
        rdata_d = 32'h0;
        if (enter_resp && (|acc_rmask)) begin
            rdata_d = mem_q[acc_idx];
        end
    end

    // ---------------------------------------------------------------------
    // Control and captured-request registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            rmask_q <= 4'd0;
            wmask_q <= 4'd0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            if (capture) begin
                idx_q   <= dmem_addr[DEPTH_LOG2+1:2];
                rmask_q <= dmem_rmask;
                wmask_q <= dmem_wmask;
                wdata_q <= dmem_wdata;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Storage array: never reset; byte-lane writes on RESP entry. The read
    // above sees the pre-write word because both happen on the same edge.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_n && enter_resp) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_wmask[i]) begin
                    mem_q[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

    assign dmem_rdata  = rdata_q;
    assign dmem_resp   = (state_q == S_RESP);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// Bench for dmem_responder. Main instance uses LATENCY=3, a second instance
// uses LATENCY=1. Expected responses (data and cycle) for the main instance
// are queued by the driver and consumed by a monitor on the falling edge.
// Cycle numbering: cyc counts rising edges; a request accepted on the edge
// that makes cyc=c0 must respond while cyc=c0+LAT-1.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int LAT = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT (LATENCY=3) ----------------
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  rmask, wmask;
    logic        resp;
    logic [1:0]  dbg_state;

    dmem_responder #(.DEPTH_LOG2(10), .LATENCY(LAT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dmem_addr   (addr),
        .dmem_rmask  (rmask),
        .dmem_wmask  (wmask),
        .dmem_wdata  (wdata),
        .dmem_rdata  (rdata),
        .dmem_resp   (resp),
        .dbg_state_o (dbg_state)
    );

    // ---------------- DUT (LATENCY=1) ----------------
    logic [31:0] addr1, wdata1, rdata1;
    logic [3:0]  rmask1, wmask1;
    logic        resp1;
    logic [1:0]  dbg_state1;

    dmem_responder #(.DEPTH_LOG2(10), .LATENCY(1)) dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .dmem_addr   (addr1),
        .dmem_rmask  (rmask1),
        .dmem_wmask  (wmask1),
        .dmem_wdata  (wdata1),
        .dmem_rdata  (rdata1),
        .dmem_resp   (resp1),
        .dbg_state_o (dbg_state1)
    );

    // ---------------- scoreboard ----------------
    int          vec = 0;
    int          err = 0;
    logic [31:0] exp_q[$];
    int          exp_cyc_q[$];
    bit          mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (resp) begin
                if (exp_q.size() == 0) begin
                    vec++;
                    err++;
                    $display("FAIL unexpected_resp: got resp=1 expected resp=0 (cyc %0d)", cyc);
                end else begin
                    chk("resp_rdata", rdata, exp_q.pop_front());
                    chk("resp_cycle", 32'(cyc), 32'(exp_cyc_q.pop_front()));
                end
            end else begin
                chk("idle_rdata_zero", rdata, 32'h0);
                if (exp_cyc_q.size() > 0 && cyc > exp_cyc_q[0]) begin
                    vec++;
                    err++;
                    $display("FAIL missed_resp: got none expected resp at cyc %0d (now %0d)",
                             exp_cyc_q[0], cyc);
                    void'(exp_q.pop_front());
                    void'(exp_cyc_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [31:0] a, input logic [3:0] rm,
                         input logic [3:0] wm, input logic [31:0] wd);
        addr  = a;
        rmask = rm;
        wmask = wm;
        wdata = wd;
    endtask

    // Full transaction on the main DUT: request, expectation, wait to IDLE.
    task automatic req(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                       input logic [31:0] wd, input logic [31:0] exp_rd);
        @(negedge clk);
        drive(a, rm, wm, wd);
        @(posedge clk);
        #1;
        exp_q.push_back(exp_rd);
        exp_cyc_q.push_back(cyc + LAT - 1);
        @(negedge clk);
        drive(32'h0, 4'h0, 4'h0, 32'h0);
        repeat (LAT) @(posedge clk);
    endtask

    // LATENCY=1 instance: response must be in the very next cycle, then gone.
    task automatic req1(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                        input logic [31:0] wd, input logic [31:0] exp_rd);
        @(negedge clk);
        addr1 = a; rmask1 = rm; wmask1 = wm; wdata1 = wd;
        @(negedge clk);
        chk("lat1_resp", 32'(resp1), 32'h1);
        chk("lat1_rdata", rdata1, exp_rd);
        addr1 = 32'h0; rmask1 = 4'h0; wmask1 = 4'h0; wdata1 = 32'h0;
        @(negedge clk);
        chk("lat1_resp_gone", 32'(resp1), 32'h0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        repeat (5000) @(posedge clk);
        vec++;
        err++;
        $display("FAIL watchdog: got no end of test expected finish before 5000 cycles");
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        drive(32'h0, 4'h0, 4'h0, 32'h0);
        addr1 = 32'h0; rmask1 = 4'h0; wmask1 = 4'h0; wdata1 = 32'h0;

        // Reset held for two edges.
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_resp", 32'(resp), 32'h0);
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_state", 32'(dbg_state), 32'h0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_state_no_req", 32'(dbg_state), 32'h0);

        // Store then load.
        req(32'h0000_0040, 4'h0, 4'hF, 32'hDEAD_BEEF, 32'h0);
        req(32'h0000_0040, 4'hF, 4'h0, 32'h0, 32'hDEAD_BEEF);

        // Byte lanes.
        req(32'h0000_0080, 4'h0, 4'hF, 32'h1122_3344, 32'h0);
        req(32'h0000_0080, 4'h0, 4'b0100, 32'h00AA_0000, 32'h0);
        req(32'h0000_0080, 4'hF, 4'h0, 32'h0, 32'h11AA_3344);
        // Load and store together: old word returned, write lands.
        req(32'h0000_0080, 4'hF, 4'b0001, 32'hFFFF_FFFF, 32'h11AA_3344);
        req(32'h0000_0080, 4'hF, 4'h0, 32'h0, 32'h11AA_33FF);

        // Capture: inputs wiggle during WAIT, request held through RESP.
        req(32'h0000_00C4, 4'h0, 4'hF, 32'h0BAD_F00D, 32'h0);
        @(negedge clk);
        drive(32'h0000_00C0, 4'h0, 4'hF, 32'h1234_5678);
        @(posedge clk);
        #1;
        exp_q.push_back(32'h0);
        exp_cyc_q.push_back(cyc + LAT - 1);
        for (int i = 0; i < LAT - 1; i++) begin
            @(negedge clk);
            drive(32'h0000_00C4, 4'hF, 4'b0011, 32'hFFFF_0000 ^ 32'(i));
        end
        @(negedge clk);
        drive(32'h0000_00C0, 4'h0, 4'hF, 32'h1234_5678);
        chk("capture_resp_cycle_state", 32'(dbg_state), 32'h2);
        @(negedge clk);
        chk("held_req_not_reaccepted", 32'(dbg_state), 32'h0);
        drive(32'h0, 4'h0, 4'h0, 32'h0);
        repeat (2) @(negedge clk);
        req(32'h0000_00C0, 4'hF, 4'h0, 32'h0, 32'h1234_5678);
        req(32'h0000_00C4, 4'hF, 4'h0, 32'h0, 32'h0BAD_F00D);

        // Reset in the first WAIT cycle drops the store.
        req(32'h0000_0100, 4'h0, 4'hF, 32'h0102_0304, 32'h0);
        @(negedge clk);
        drive(32'h0000_0100, 4'h0, 4'hF, 32'h5A5A_5A5A);
        @(posedge clk);
        @(negedge clk);
        chk("midop_in_wait", 32'(dbg_state), 32'h1);
        drive(32'h0, 4'h0, 4'h0, 32'h0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midop_reset_state", 32'(dbg_state), 32'h0);
        repeat (5) @(negedge clk);
        req(32'h0000_0100, 4'hF, 4'h0, 32'h0, 32'h0102_0304);

        // Aliasing on the upper address bits and ignored low bits.
        req(32'h0000_1004, 4'h0, 4'hF, 32'hCAFE_F00D, 32'h0);
        req(32'h0000_0004, 4'hF, 4'h0, 32'h0, 32'hCAFE_F00D);
        req(32'h8000_0007, 4'hF, 4'h0, 32'h0, 32'hCAFE_F00D);

        // LATENCY=1 instance.
        req1(32'h0000_0200, 4'h0, 4'hF, 32'h7766_5544, 32'h0);
        req1(32'h0000_0200, 4'hF, 4'h0, 32'h0, 32'h7766_5544);
        req1(32'h0000_0200, 4'hF, 4'b1000, 32'h9900_0000, 32'h7766_5544);
        req1(32'h0000_0200, 4'hF, 4'h0, 32'h0, 32'h9966_5544);

        repeat (6) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        mon_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
